// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus-based CPU datapath.
// Steps fetch T0-T2 and decodes IR[31:27] into execute steps T3-T7.
module control_sequencer #(
  parameter int OPW = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011,
  parameter logic [OPW-1:0] ALU_SUB = 5'b00100,
  parameter logic [OPW-1:0] ALU_AND = 5'b00101,
  parameter logic [OPW-1:0] ALU_OR  = 5'b00110
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic [31:0]    IR,
  input  logic           CON,
  input  logic           Stop,
  output logic           Run,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           CONin,
  output logic           OUTPORTin,
  output logic           Rin,
  output logic           PCout,
  output logic           MDRout,
  output logic           ZLOout,
  output logic           ZHIout,
  output logic           HIout,
  output logic           LOout,
  output logic           INPORTout,
  output logic           Cout,
  output logic           Rout,
  output logic           BAout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] ALUop
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, state_nx, state_end;

  logic [4:0] op;
  logic is_r, is_i, is_ldi, is_ld, is_st;
  logic is_br, is_jr, is_in, is_out;
  logic is_mfhi, is_mflo, is_halt;
  logic [OPW-1:0] imm_op;
  logic unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_r    = (op == ALU_ADD) || (op == ALU_SUB)
                || (op == ALU_AND) || (op == ALU_OR);
  assign is_i    = (op == OP_ADDI) || (op == OP_ANDI)
                || (op == OP_ORI);
  assign is_ldi  = (op == OP_LDI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_br   = (op == OP_BR);
  assign is_jr   = (op == OP_JR);
  assign is_in   = (op == OP_IN);
  assign is_out  = (op == OP_OUT);
  assign is_mfhi = (op == OP_MFHI);
  assign is_mflo = (op == OP_MFLO);
  assign is_halt = (op == OP_HALT);

  always_comb begin
    imm_op = ALU_ADD;
    if (op == OP_ANDI) imm_op = ALU_AND;
    if (op == OP_ORI)  imm_op = ALU_OR;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_RST;
    else          state <= state_nx;
  end

  // Stop is only honoured on the final step of an instruction.
  assign state_end = Stop ? S_HALT : S_T0;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:  state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2:   state_nx = S_T3;
      S_T3: begin
        if (is_halt)
          state_nx = S_HALT;
        else if (is_r | is_i | is_ldi | is_ld | is_st | is_br)
          state_nx = S_T4;
        else
          state_nx = state_end;
      end
      S_T4:   state_nx = S_T5;
      S_T5:   state_nx = (is_ld | is_st | is_br) ? S_T6 : state_end;
      S_T6:   state_nx = is_br ? state_end : S_T7;
      S_T7:   state_nx = state_end;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    Run = 1'b0; PCin = 1'b0; IRin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0; HIin = 1'b0;
    LOin = 1'b0; CONin = 1'b0; OUTPORTin = 1'b0; Rin = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; INPORTout = 1'b0; Cout = 1'b0;
    Rout = 1'b0; BAout = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    ALUop = '0;
    unique case (state)
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Run = 1'b1; ZLOout = 1'b1; PCin = 1'b1;
        Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        unique case (1'b1)
          is_r, is_i: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          is_ldi, is_ld, is_st: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end
          is_br: begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          end
          is_jr: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          is_in: begin
            INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_out: begin
            Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1;
          end
          is_mfhi: begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_mflo: begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        unique case (1'b1)
          is_r: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op;
          end
          is_i: begin
            Cout = 1'b1; Zin = 1'b1; ALUop = imm_op;
          end
          is_ldi, is_ld, is_st: begin
            Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD;
          end
          is_br: begin
            PCout = 1'b1; Yin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        Run = 1'b1;
        unique case (1'b1)
          is_r, is_i, is_ldi: begin
            ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_ld, is_st: begin
            ZLOout = 1'b1; MARin = 1'b1;
          end
          is_br: begin
            Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        Run = 1'b1;
        unique case (1'b1)
          is_ld: begin
            Read = 1'b1; MDRin = 1'b1;
          end
          is_st: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end
          is_br: begin
            ZLOout = CON; PCin = CON;
          end
          default: ;
        endcase
      end
      S_T7: begin
        Run = 1'b1;
        unique case (1'b1)
          is_ld: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_st: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class
// through its T-states and compares every control line per cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = '0;
  logic        con = 1'b0;
  logic        stop = 1'b0;

  logic run, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
  logic hi_in, lo_in, con_in, outport_in, r_in;
  logic pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out;
  logic inport_out, c_out, r_out, ba_out;
  logic gra, grb, grc, inc_pc, rd, wr;
  logic [4:0] alu;
  logic [27:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] RUN    = 28'd1 << 27;
  localparam logic [27:0] PCIN   = 28'd1 << 26;
  localparam logic [27:0] IRIN   = 28'd1 << 25;
  localparam logic [27:0] MARIN  = 28'd1 << 24;
  localparam logic [27:0] MDRIN  = 28'd1 << 23;
  localparam logic [27:0] YIN    = 28'd1 << 22;
  localparam logic [27:0] ZIN    = 28'd1 << 21;
  localparam logic [27:0] CONIN  = 28'd1 << 18;
  localparam logic [27:0] OPIN   = 28'd1 << 17;
  localparam logic [27:0] RIN    = 28'd1 << 16;
  localparam logic [27:0] PCOUT  = 28'd1 << 15;
  localparam logic [27:0] MDROUT = 28'd1 << 14;
  localparam logic [27:0] ZLOOUT = 28'd1 << 13;
  localparam logic [27:0] HIOUT  = 28'd1 << 11;
  localparam logic [27:0] LOOUT  = 28'd1 << 10;
  localparam logic [27:0] IPOUT  = 28'd1 << 9;
  localparam logic [27:0] COUT   = 28'd1 << 8;
  localparam logic [27:0] ROUT   = 28'd1 << 7;
  localparam logic [27:0] BAOUT  = 28'd1 << 6;
  localparam logic [27:0] GRA    = 28'd1 << 5;
  localparam logic [27:0] GRB    = 28'd1 << 4;
  localparam logic [27:0] GRC    = 28'd1 << 3;
  localparam logic [27:0] INCPC  = 28'd1 << 2;
  localparam logic [27:0] READ   = 28'd1 << 1;
  localparam logic [27:0] WRITE  = 28'd1 << 0;

  assign ctl = {run, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                hi_in, lo_in, con_in, outport_in, r_in,
                pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out,
                inport_out, c_out, r_out, ba_out,
                gra, grb, grc, inc_pc, rd, wr};

  control_sequencer dut (
    .Clock(clk), .Reset_n(rst_n), .IR(ir), .CON(con), .Stop(stop),
    .Run(run), .PCin(pc_in), .IRin(ir_in), .MARin(mar_in),
    .MDRin(mdr_in), .Yin(y_in), .Zin(z_in), .HIin(hi_in),
    .LOin(lo_in), .CONin(con_in), .OUTPORTin(outport_in),
    .Rin(r_in), .PCout(pc_out), .MDRout(mdr_out),
    .ZLOout(zlo_out), .ZHIout(zhi_out), .HIout(hi_out),
    .LOout(lo_out), .INPORTout(inport_out), .Cout(c_out),
    .Rout(r_out), .BAout(ba_out), .Gra(gra), .Grb(grb),
    .Grc(grc), .IncPC(inc_pc), .Read(rd), .Write(wr),
    .ALUop(alu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One state per call: sample on the falling edge.
  task automatic step(input string tag, input logic [27:0] exp,
                      input bit chk_alu, input logic [4:0] aop);
    @(negedge clk);
    check(tag, {4'h0, ctl}, {4'h0, exp});
    if (chk_alu) check({tag, "_alu"}, {27'h0, alu}, {27'h0, aop});
  endtask

  // IR only changes after T0 so the previous instruction's
  // final-state decode is never disturbed.
  task automatic fetch(input logic [31:0] nir, input logic c);
    step("t0", RUN | PCOUT | MARIN | INCPC | ZIN, 0, 5'h0);
    ir  = nir;
    con = c;
    step("t1", RUN | ZLOOUT | PCIN | READ | MDRIN, 0, 5'h0);
    step("t2", RUN | MDROUT | IRIN, 0, 5'h0);
  endtask

  task automatic alu_op(input logic [31:0] nir,
                        input logic [4:0] aop, input bit imm);
    fetch(nir, 1'b0);
    step("alu_t3", RUN | GRB | ROUT | YIN, 0, 5'h0);
    step("alu_t4", RUN | ZIN | (imm ? COUT : (GRC | ROUT)), 1, aop);
    step("alu_t5", RUN | ZLOOUT | GRA | RIN, 0, 5'h0);
  endtask

  task automatic mem_head(input logic [31:0] nir);
    fetch(nir, 1'b0);
    step("mem_t3", RUN | GRB | BAOUT | YIN, 0, 5'h0);
    step("mem_t4", RUN | COUT | ZIN, 1, 5'b00011);
  endtask

  task automatic br_op(input logic c);
    fetch(32'h9280_0005, c);
    step("br_t3", RUN | GRA | ROUT | CONIN, 0, 5'h0);
    step("br_t4", RUN | PCOUT | YIN, 0, 5'h0);
    step("br_t5", RUN | COUT | ZIN, 1, 5'b00011);
    step(c ? "br_t6_taken" : "br_t6_not",
         RUN | (c ? (ZLOOUT | PCIN) : 28'h0), 0, 5'h0);
  endtask

  task automatic single(input logic [31:0] nir, input logic [27:0] e3);
    fetch(nir, 1'b0);
    step("single_t3", RUN | e3, 0, 5'h0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("rst_async", {4'h0, ctl}, 32'h0);
    check("rst_async_alu", {27'h0, alu}, 32'h0);
    @(negedge clk);
    check("rst_hold", {4'h0, ctl}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    check("por0", {4'h0, ctl}, 32'h0);
    @(negedge clk);
    check("por1", {4'h0, ctl}, 32'h0);
    check("por_alu", {27'h0, alu}, 32'h0);
    rst_n = 1'b1;

    alu_op(32'h191A_0000, 5'b00011, 0);
    alu_op(32'h2000_0000, 5'b00100, 0);
    alu_op(32'h2800_0000, 5'b00101, 0);
    alu_op(32'h3000_0000, 5'b00110, 0);
    alu_op(32'h6000_0000, 5'b00011, 1);
    alu_op(32'h6800_0000, 5'b00101, 1);
    alu_op(32'h7000_0000, 5'b00110, 1);

    mem_head(32'h0800_0055);
    step("ldi_t5", RUN | ZLOOUT | GRA | RIN, 0, 5'h0);

    mem_head(32'h0000_0055);
    step("ld_t5", RUN | ZLOOUT | MARIN, 0, 5'h0);
    step("ld_t6", RUN | READ | MDRIN, 0, 5'h0);
    step("ld_t7", RUN | MDROUT | GRA | RIN, 0, 5'h0);

    mem_head(32'h1000_0055);
    step("st_t5", RUN | ZLOOUT | MARIN, 0, 5'h0);
    step("st_t6", RUN | GRA | ROUT | MDRIN, 0, 5'h0);
    step("st_t7", RUN | WRITE, 0, 5'h0);

    br_op(1'b1);
    br_op(1'b0);

    single(32'h9800_0000, GRA | ROUT | PCIN);
    single(32'hA800_0000, IPOUT | GRA | RIN);
    single(32'hB000_0000, GRA | ROUT | OPIN);
    single(32'hB800_0000, HIOUT | GRA | RIN);
    single(32'hC000_0000, LOOUT | GRA | RIN);
    single(32'hC800_0000, 28'h0);
    single(32'hF800_0000, 28'h0);

    single(32'hD000_0000, 28'h0);
    for (int i = 0; i < 20; i++) step("halt_frozen", 28'h0, 0, 5'h0);
    do_reset();

    fetch(32'h191A_0000, 1'b0);
    step("stop_t3", RUN | GRB | ROUT | YIN, 0, 5'h0);
    stop = 1'b1;
    step("stop_t4", RUN | GRC | ROUT | ZIN, 1, 5'b00011);
    step("stop_t5", RUN | ZLOOUT | GRA | RIN, 0, 5'h0);
    step("stop_halt0", 28'h0, 0, 5'h0);
    stop = 1'b0;
    step("stop_halt1", 28'h0, 0, 5'h0);
    step("stop_halt2", 28'h0, 0, 5'h0);
    do_reset();

    mem_head(32'h0000_0055);
    step("ldr_t5", RUN | ZLOOUT | MARIN, 0, 5'h0);
    step("ldr_t6", RUN | READ | MDRIN, 0, 5'h0);
    do_reset();
    alu_op(32'h191A_0000, 5'b00011, 0);
    step("final_t0", RUN | PCOUT | MARIN | INCPC | ZIN, 0, 5'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the 32-bit bus-based CPU datapath.
- Decodes the IR opcode and steps T-states: fetch T0–T2, then T3–T7 execute.
- Drives every register in/out select, Gra/Grb/Grc, ALU op, and memory Read/Write strobe, so the datapath runs programs without a testbench sequencing it.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALU_ADD, 5'b00011, ALUop code for add.
- ALU_SUB, 5'b00100, ALUop code for subtract.
- ALU_AND, 5'b00101, ALUop code for and.
- ALU_OR, 5'b00110, ALUop code for or.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- IR  in  32  instruction register contents.
- CON  in  1  branch-condition flag from the datapath CON FF.
- Stop  in  1  halt request, sampled at instruction boundary.
- Run  out  1  high while executing.
- Register in-enables, out 1 each: PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin, Rin.
- Bus out-enables, out 1 each: PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout, Rout, BAout.
- Register selects, out 1 each: Gra, Grb, Grc.
- Control strobes, out 1 each: IncPC, Read, Write.
- ALUop  out  5  ALU function select; don't-care when Zin=0.

Behaviour:
- States:
  - RST: all outputs 0, Run=0.
  - T0..T7: one clock each.
  - HALT: all outputs 0, Run=0.
- Reset:
  - Reset_n low forces RST immediately, including mid-instruction; all outputs go 0 asynchronously.
  - First rising edge with Reset_n high: RST→T0.
- Moore outputs:
  - Decoded from state and IR only; stable for the whole state.
  - Exception: br T6 also uses CON.
  - Any signal not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3 decodes the new IR.
- Opcodes (IR[31:27]) and execute steps:
  - add 00011, sub 00100, and 00101, or 00110: T3 Grb Rout Yin; T4 Grc Rout Zin, ALUop=opcode; T5 ZLOout Gra Rin.
  - addi 01100, andi 01101, ori 01110: as R-type, but T4 uses Cout instead of Grc Rout. ALUop = ADD/AND/OR respectively.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout Zin ALU_ADD; T5 ZLOout Gra Rin.
  - ld 00000: ldi T3–T4; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st 00010: ld T3–T5; T6 Gra Rout MDRin with Read=0; T7 Write.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin ALU_ADD; T6 ZLOout PCin only if CON=1, else idle.
  - jr 10011: T3 Gra Rout PCin.
  - in 10101: T3 INPORTout Gra Rin.
  - out 10110: T3 Gra Rout OUTPORTin.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - nop 11001: T3 idle.
  - halt 11010: T3→HALT.
  - Any other opcode: treated as nop.
- Transitions:
  - The last execute state of each instruction returns to T0, unless Stop=1 at that edge, which goes to HALT.
  - Cycle counts: R/I-type and ldi 6; ld and st 8; br 7; single-step ops 4.
- HALT exits only via Reset_n. Stop has no effect mid-instruction.
- Run=1 in T0..T7.
- Never asserted together:
  - two bus drivers;
  - Read with Write.

Test Plan:
- Reset_n low 2 cycles, release → next edge in T0, PCout=MARin=IncPC=Zin=1, Run=1. Every output is 0 while Reset_n is low.
- IR=0x191A0000 (add R2,R3,R4) → T4 ALUop=00011 with Grc Rout Zin; T5 Gra Rin ZLOout; back in T0 exactly 6 cycles after entering T0.
- ld, then st, with C=0x55 → ld asserts Read MDRin at T6 and Gra Rin at T7. st has Write=1 only in T7 and Read=0 throughout T6–T7. Each is 8 cycles.
- IR=0x92800005 (br R5) with CON=1 → ZLOout PCin in T6. Same IR with CON=0 → T6 all zero. Both return to T0 after 7 cycles.
- IR=0xD0000000 (halt) → HALT after T3, Run=0, state frozen for 20 cycles. Stop=1 during an add → add completes, then HALT.
- Reset_n pulsed low during ld T6 → outputs 0 immediately, RST then T0 on release. Opcode 11111 → nop timing, no Rin/Write/PCin.
